// File: rtl/result_drain_pkg.sv
// Shared constants, state encoding and mask helper for the result drain chain.
package result_drain_pkg;

  // Counter width for pend and WordCnt (DEPTH is limited to 1..255).
  localparam int unsigned CNT_W = 8;

  // Upper bounds for the mask helper; every instance must fit inside them.
  localparam int unsigned MAX_CH = 32;
  localparam int unsigned MAX_W  = 1024;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t LAST  = 2'd2;

  // Expands a per-channel enable into a per-bit mask; callers truncate to W.
  function automatic logic [MAX_W-1:0] expand_mask(input logic [MAX_CH-1:0] ch_en,
                                                   input int unsigned ch_bits,
                                                   input int unsigned ch_n);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < ch_n * ch_bits) m[10'(i)] = ch_en[5'(i / ch_bits)];
    end
    return m;
  endfunction

endpackage

// File: rtl/result_drain_ctrl.sv
// Drain sequencer: FSM, word counters and the handshake signals of one stage.
module result_drain_ctrl
  import result_drain_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             InValid,
  input  logic             OutReady,
  output logic             InReady,
  output logic             OutValid,
  output logic             Busy,
  output logic [CNT_W-1:0] WordCnt,
  output logic             Done,
  output logic             load_local,
  output logic             load_in
);

  state_t           state_q;
  logic [CNT_W-1:0] pend_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic             out_valid_q;
  logic             done_q;
  logic             out_xfer;
  logic             in_xfer;

  // Handshake decode; upstream is only accepted while forwarding.
  always_comb begin
    out_xfer   = out_valid_q & OutReady;
    InReady    = (state_q == SHIFT) & (~out_valid_q | OutReady);
    in_xfer    = InValid & InReady;
    // A Start coinciding with the Done pulse is dropped.
    load_local = (state_q == IDLE) & Start & ~done_q;
    load_in    = in_xfer;
  end

  // State, pending-word count, delivered-word count and Done pulse.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      word_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_local) begin
            out_valid_q <= 1'b1;
            pend_q      <= CNT_W'(DEPTH - 1);
            word_cnt_q  <= '0;
            state_q     <= (DEPTH > 1) ? SHIFT : LAST;
          end
        end
        SHIFT: begin
          if (out_xfer) word_cnt_q <= word_cnt_q + CNT_W'(1);
          if (in_xfer) begin
            out_valid_q <= 1'b1;
            pend_q      <= pend_q - CNT_W'(1);
            if (pend_q == CNT_W'(1)) state_q <= LAST;
          end else if (out_xfer) begin
            out_valid_q <= 1'b0;
          end
        end
        LAST: begin
          if (out_xfer) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            word_cnt_q  <= word_cnt_q + CNT_W'(1);
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign OutValid = out_valid_q;
  assign Busy     = (state_q != IDLE);
  assign WordCnt  = word_cnt_q;
  assign Done     = done_q;

endmodule

// File: rtl/result_drain_chain.sv
// One drain-chain stage: masked output register fed by local or upstream results.
module result_drain_chain
  import result_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK       = 4,
  parameter int unsigned CH         = 4,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned W         = CH * PACK * DATA_WIDTH
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [CH-1:0]    ChEn,
  input  logic [W-1:0]     ResultLocal,
  input  logic [W-1:0]     ResultIn,
  input  logic             InValid,
  output logic             InReady,
  output logic [W-1:0]     ResultOut,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             Busy,
  output logic [CNT_W-1:0] WordCnt,
  output logic             Done
);

  logic [CH-1:0] mask_q;
  logic [W-1:0]  data_q;
  logic [W-1:0]  start_mask;
  logic [W-1:0]  hold_mask;
  logic          load_local;
  logic          load_in;

  // Local word uses the incoming ChEn; forwarded words use the mask latched at Start.
  always_comb begin
    start_mask = W'(expand_mask(MAX_CH'(ChEn), PACK * DATA_WIDTH, CH));
    hold_mask  = W'(expand_mask(MAX_CH'(mask_q), PACK * DATA_WIDTH, CH));
  end

  result_drain_ctrl #(
    .DEPTH(DEPTH)
  ) u_ctrl (
    .Clk       (Clk),
    .rst       (rst),
    .Start     (Start),
    .InValid   (InValid),
    .OutReady  (OutReady),
    .InReady   (InReady),
    .OutValid  (OutValid),
    .Busy      (Busy),
    .WordCnt   (WordCnt),
    .Done      (Done),
    .load_local(load_local),
    .load_in   (load_in)
  );

  // Output data register and channel mask.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      mask_q <= '1;
    end else if (load_local) begin
      data_q <= ResultLocal & start_mask;
      mask_q <= ChEn;
    end else if (load_in) begin
      data_q <= ResultIn & hold_mask;
    end
  end

  assign ResultOut = data_q;

endmodule

// File: tb/tb_result_drain_chain.sv
// Scoreboard bench: two stages (DEPTH=1 and DEPTH=4) with 32-bit words.
module tb_result_drain_chain;

  logic        Clk = 1'b0;
  logic        rst;
  logic        start1, start4;
  logic [3:0]  ChEn;
  logic [31:0] ResultLocal, ResultIn;
  logic        InValid, OutReady;

  logic        InReady1, OutValid1, Busy1, Done1;
  logic [31:0] ResultOut1;
  logic [7:0]  WordCnt1;
  logic        InReady4, OutValid4, Busy4, Done4;
  logic [31:0] ResultOut4;
  logic [7:0]  WordCnt4;

  int checks   = 0;
  int failures = 0;
  int n4       = 0;
  logic [31:0] exp1[$];
  logic [31:0] exp4[$];

  always #5 Clk = ~Clk;

  result_drain_chain #(.DATA_WIDTH(8), .PACK(1), .CH(4), .DEPTH(1)) u_d1 (
    .Clk(Clk), .rst(rst), .Start(start1), .ChEn(ChEn), .ResultLocal(ResultLocal),
    .ResultIn(ResultIn), .InValid(InValid), .InReady(InReady1), .ResultOut(ResultOut1),
    .OutValid(OutValid1), .OutReady(OutReady), .Busy(Busy1), .WordCnt(WordCnt1), .Done(Done1)
  );

  result_drain_chain #(.DATA_WIDTH(8), .PACK(1), .CH(4), .DEPTH(4)) u_d4 (
    .Clk(Clk), .rst(rst), .Start(start4), .ChEn(ChEn), .ResultLocal(ResultLocal),
    .ResultIn(ResultIn), .InValid(InValid), .InReady(InReady4), .ResultOut(ResultOut4),
    .OutValid(OutValid4), .OutReady(OutReady), .Busy(Busy4), .WordCnt(WordCnt4), .Done(Done4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at posedge+1; leaves Start low at the next posedge+1.
  task automatic start_drain4(input logic [31:0] l, input logic [3:0] en);
    ResultLocal = l;
    ChEn        = en;
    start4      = 1'b1;
    @(posedge Clk); #1;
    start4      = 1'b0;
  endtask

  // Offers one upstream word and waits for its handshake.
  task automatic feed_word(input logic [31:0] w, input logic [31:0] e);
    bit ok;
    ok = 1'b0;
    exp4.push_back(e);
    ResultIn = w;
    InValid  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (InReady4) begin
        ok = 1'b1;
        break;
      end
    end
    chk("feed_handshake", 32'(ok), 32'd1);
    @(posedge Clk); #1;
  endtask

  task automatic wait_done4(output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      n++;
      if (Done4) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done4_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    logic [31:0] snap;
    rst = 1'b0; start1 = 1'b0; start4 = 1'b0; ChEn = 4'hF;
    ResultLocal = '0; ResultIn = '0; InValid = 1'b0; OutReady = 1'b1;

    // Monitors pop the scoreboard whenever a word is accepted downstream.
    fork
      forever begin
        @(negedge Clk);
        if (rst && OutValid4 && OutReady) begin
          if (exp4.size() == 0) begin
            checks++; failures++;
            $display("FAIL d4_extra_word actual=%h required=none", ResultOut4);
          end else begin
            chk("d4_word", ResultOut4, exp4.pop_front());
            n4++;
          end
        end
      end
      forever begin
        @(negedge Clk);
        if (rst && OutValid1 && OutReady) begin
          if (exp1.size() == 0) begin
            checks++; failures++;
            $display("FAIL d1_extra_word actual=%h required=none", ResultOut1);
          end else begin
            chk("d1_word", ResultOut1, exp1.pop_front());
          end
        end
      end
    join_none

    // Reset values
    #1;
    chk("rst_out", ResultOut4, 32'h0);
    chk("rst_valid", 32'(OutValid4), 32'd0);
    chk("rst_inready", 32'(InReady4), 32'd0);
    chk("rst_busy", 32'(Busy4), 32'd0);
    chk("rst_wordcnt", 32'(WordCnt4), 32'd0);
    chk("rst_done", 32'(Done4), 32'd0);
    @(posedge Clk); #1;
    rst = 1'b1;
    @(posedge Clk); #1;

    // Reset mid-drain clears everything immediately
    OutReady = 1'b0;
    start_drain4(32'hAABB_CCDD, 4'hF);
    chk("mid_busy", 32'(Busy4), 32'd1);
    chk("mid_valid", 32'(OutValid4), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_out", ResultOut4, 32'h0);
    chk("midrst_valid", 32'(OutValid4), 32'd0);
    chk("midrst_busy", 32'(Busy4), 32'd0);
    chk("midrst_wordcnt", 32'(WordCnt4), 32'd0);
    @(posedge Clk); #1;
    rst = 1'b1;
    OutReady = 1'b1;
    @(posedge Clk); #1;

    // DEPTH=1 local capture
    ResultLocal = 32'h0403_0201;
    ChEn = 4'hF;
    exp1.push_back(32'h0403_0201);
    start1 = 1'b1;
    @(posedge Clk); #1;
    start1 = 1'b0;
    @(negedge Clk);
    chk("d1_valid", 32'(OutValid1), 32'd1);
    chk("d1_out", ResultOut1, 32'h0403_0201);
    @(negedge Clk);
    chk("d1_done", 32'(Done1), 32'd1);
    chk("d1_wordcnt", 32'(WordCnt1), 32'd1);
    @(posedge Clk); #1;

    // Streaming L,A1,A2,A3 at one word per cycle
    base = n4;
    exp4.push_back(32'h1111_2222);
    start_drain4(32'h1111_2222, 4'hF);
    feed_word(32'hA1A1_0001, 32'hA1A1_0001);
    feed_word(32'hA2A2_0002, 32'hA2A2_0002);
    feed_word(32'hA3A3_0003, 32'hA3A3_0003);
    InValid = 1'b0;
    wait_done4(n);
    chk("stream_done_lat", 32'(n), 32'd2);
    chk("stream_wordcnt", 32'(WordCnt4), 32'd4);
    chk("stream_words", 32'(n4 - base), 32'd4);
    @(posedge Clk); #1;

    // Backpressure for 3 cycles mid-drain
    base = n4;
    exp4.push_back(32'h0101_0101);
    start_drain4(32'h0101_0101, 4'hF);
    fork
      begin
        feed_word(32'hB1B1_0001, 32'hB1B1_0001);
        feed_word(32'hB2B2_0002, 32'hB2B2_0002);
        feed_word(32'hB3B3_0003, 32'hB3B3_0003);
        InValid = 1'b0;
      end
      begin
        @(posedge Clk); #1;
        OutReady = 1'b0;
        snap = ResultOut4;
        for (int i = 0; i < 3; i++) begin
          @(negedge Clk);
          chk("bp_stable", ResultOut4, snap);
          chk("bp_inready", 32'(InReady4), 32'd0);
          chk("bp_valid", 32'(OutValid4), 32'd1);
        end
        @(posedge Clk); #1;
        OutReady = 1'b1;
      end
    join
    wait_done4(n);
    chk("bp_wordcnt", 32'(WordCnt4), 32'd4);
    chk("bp_words", 32'(n4 - base), 32'd4);
    @(posedge Clk); #1;

    // Channel mask 0101 on local and upstream paths
    exp4.push_back(32'h0034_0078);
    start_drain4(32'h1234_5678, 4'b0101);
    ChEn = 4'hF;  // latched mask must still apply to forwarded words
    feed_word(32'hFFFF_FFFF, 32'h00FF_00FF);
    feed_word(32'hFFFF_FFFF, 32'h00FF_00FF);
    feed_word(32'hFFFF_FFFF, 32'h00FF_00FF);
    InValid = 1'b0;
    wait_done4(n);
    @(posedge Clk); #1;

    // Protocol: InValid in IDLE, Start while Busy, Start during Done
    InValid  = 1'b1;
    ResultIn = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("idle_inready", 32'(InReady4), 32'd0);
      chk("idle_valid", 32'(OutValid4), 32'd0);
    end
    @(posedge Clk); #1;
    base = n4;
    exp4.push_back(32'h5555_AAAA);
    start_drain4(32'h5555_AAAA, 4'hF);
    fork
      begin
        feed_word(32'hC1C1_0001, 32'hC1C1_0001);
        feed_word(32'hC2C2_0002, 32'hC2C2_0002);
        feed_word(32'hC3C3_0003, 32'hC3C3_0003);
      end
      begin
        @(posedge Clk); #1;
        start4 = 1'b1;
        @(posedge Clk); #1;
        start4 = 1'b0;
      end
    join
    wait_done4(n);
    start4 = 1'b1;
    @(posedge Clk); #1;
    start4 = 1'b0;
    @(negedge Clk);
    chk("done_start_busy", 32'(Busy4), 32'd0);
    chk("done_start_valid", 32'(OutValid4), 32'd0);
    chk("done_start_inready", 32'(InReady4), 32'd0);
    chk("proto_wordcnt", 32'(WordCnt4), 32'd4);
    repeat (3) @(negedge Clk);
    InValid = 1'b0;
    chk("proto_words", 32'(n4 - base), 32'd4);

    chk("exp4_empty", 32'(exp4.size()), 32'd0);
    chk("exp1_empty", 32'(exp1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
